// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_access_ctrl_pkg                                           |
// | Desc    : Shared state encodings, Funct3 access codes and lane helpers.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package dmem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   function automatic logic f3_is_legal(input logic [2:0] f3);
      case (f3)
         LS_B, LS_H, LS_W, LS_BU, LS_HU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // size is Funct3[1:0]: 00 byte, 01 half, 10 word
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 1'b1;
         2'b01:   return ~lane[0];
         2'b10:   return (lane == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
      case (size)
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : load_extend                                                    |
// | Desc    : Lane select plus sign/zero extension of a loaded word.         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module load_extend
   import dmem_access_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  Funct3,
   output logic [31:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = word[{addr, 3'b000} +: 8];
   assign w_half = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      data = word;
      case (Funct3)
         LS_B:    data = {{24{w_byte[7]}}, w_byte};
         LS_H:    data = {{16{w_half[15]}}, w_half};
         LS_BU:   data = {24'd0, w_byte};
         LS_HU:   data = {16'd0, w_half};
         default: data = word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_access_ctrl                                               |
// | Desc    : Load/store sequencer to a variable-latency data memory.        |
// |           Optional REQ timeout abort enabled by DMEM_TIMEOUT_EN.         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int BITS           = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BITS-1:0]   wdata,
   output logic              stall,
   output logic [BITS-1:0]   rdata,
   output logic              rdata_vld,
   output logic              access_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [BITS-1:0]   mem_wdata,
   input  logic              mem_ready,
   input  logic [BITS-1:0]   mem_rdata
);

   if (BITS != 32) begin : g_bits_check
      $error("dmem_access_ctrl: BITS must be 32");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_timeout_check
      $error("dmem_access_ctrl: TIMEOUT_CYCLES must be 1..256");
   end

   dmem_state_t r_state;
   logic [1:0]  r_lane;
   logic [2:0]  r_f3;
   logic        r_is_load;
   logic        r_rdata_vld;
   logic        r_tmo_err;

   logic        w_req;
   logic        w_legal;
   logic        w_accept;
   logic        w_reject;
   logic [31:0] w_ext;

`ifdef DMEM_TIMEOUT_EN
   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_tmo_cnt;
`endif

   assign w_req    = MemRead | MemWrite;
   assign w_legal  = f3_is_legal(Funct3) && is_aligned(Funct3[1:0], addr[1:0]);
   assign w_accept = (r_state == IDLE) && w_req && w_legal;
   assign w_reject = (r_state == IDLE) && w_req && !w_legal;

   // IDLE must hold the core in the same cycle it accepts the access
   assign stall      = w_accept || (r_state == REQ);
   assign access_err = w_reject || r_tmo_err;
   assign rdata_vld  = r_rdata_vld;

   load_extend u_load_extend (
      .word   (mem_rdata),
      .addr   (r_lane),
      .Funct3 (r_f3),
      .data   (w_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_lane      <= '0;
         r_f3        <= '0;
         r_is_load   <= 1'b0;
         r_rdata_vld <= 1'b0;
         r_tmo_err   <= 1'b0;
         rdata       <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= '0;
         mem_wdata   <= '0;
`ifdef DMEM_TIMEOUT_EN
         r_tmo_cnt   <= '0;
`endif
      end else begin
         r_rdata_vld <= 1'b0;
         r_tmo_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state   <= REQ;
                  r_lane    <= addr[1:0];
                  r_f3      <= Funct3;
                  r_is_load <= ~MemWrite;
                  mem_req   <= 1'b1;
                  mem_we    <= MemWrite;
                  mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  mem_be    <= byte_enables(Funct3[1:0], addr[1:0]);
                  mem_wdata <= store_replicate(Funct3[1:0], wdata);
`ifdef DMEM_TIMEOUT_EN
                  r_tmo_cnt <= '0;
`endif
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  r_state <= RESP;
                  if (r_is_load) begin
                     rdata       <= w_ext;
                     r_rdata_vld <= 1'b1;
                  end
               end
`ifdef DMEM_TIMEOUT_EN
               else if (r_tmo_cnt == c_tmo_last) begin
                  mem_req   <= 1'b0;
                  r_state   <= RESP;
                  r_tmo_err <= 1'b1;
                  if (r_is_load) begin
                     rdata       <= '0;
                     r_rdata_vld <= 1'b1;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
`endif
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle sequencer between the core's memory stage and a single-port data memory with variable latency.
- Accepts load/store requests decoded by the control unit (MemRead/MemWrite, Funct3), issues one request/ready handshake to memory, and holds the core with a stall.
- Generates byte-lane enables and returns sign- or zero-extended load data.
- Rejects misaligned and illegal-size accesses without touching memory.

Parameters:
- BITS, 32, data word width; fixed at 32 for byte-lane logic.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 16, maximum cycles in REQ before abort; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load request from control unit.
- MemWrite  in  1  store request from control unit.
- Funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  ADDR_W  byte address from ALU.
- wdata  in  BITS  store data (rs2).
- stall  out  1  hold PC and pipeline registers.
- rdata  out  BITS  extended load result; valid while rdata_vld=1.
- rdata_vld  out  1  one-cycle pulse on load completion.
- access_err  out  1  one-cycle pulse: misaligned, illegal Funct3 or timeout.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, low two bits 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  BITS  lane-replicated store data.
- mem_ready  in  1  memory completes the transfer in the cycle it is sampled high with mem_req=1.
- mem_rdata  in  BITS  read word, valid with mem_ready.

Behaviour:
- Reset (async, immediate): state IDLE. stall, rdata_vld, access_err, mem_req and mem_we = 0. rdata, mem_addr, mem_be and mem_wdata = 0. Reset mid-transaction drops mem_req at once; the memory must tolerate the abandoned request.
- States: IDLE, REQ, RESP.
- IDLE:
  - On MemRead|MemWrite with a legal, aligned access: latch addr, wdata and Funct3, set mem_req=1 at the next edge, go to REQ. stall=1 combinationally in this same cycle.
  - If both MemRead and MemWrite are set, the store wins.
  - Aligned means: halfword addr[0]=0; word addr[1:0]=00.
  - Misaligned access or Funct3 in {011, 110, 111}: access_err=1 for this cycle, stall=0, no request, stay IDLE.
- REQ:
  - mem_req=1 and stall=1.
  - mem_ready=1: capture mem_rdata, drop mem_req at the next edge, go to RESP.
  - No mem_ready: wait indefinitely; the only exit is the optional timeout.
- RESP:
  - stall=0, so the core advances at this edge.
  - For a load, rdata_vld=1 for this cycle.
  - Next state is IDLE, which sees the next instruction.
  - Minimum latency with zero-wait memory: 3 cycles (IDLE, REQ, RESP).
- Byte enables:
  - byte: 0001 << addr[1:0].
  - half: 0011 << addr[1:0].
  - word: 1111.
- mem_wdata replication: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extract: select the lane by latched addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- Store completion does not pulse rdata_vld, and rdata keeps its previous value.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit cycle counter clears on entry to REQ and increments each REQ cycle.
  - On reaching TIMEOUT_CYCLES-1 without mem_ready: drop mem_req, pulse access_err, go to RESP with rdata=0. rdata_vld still pulses for loads.
  - mem_ready in the same cycle as the limit wins; no error is raised.
- Undefined: no counter; REQ waits forever.

Decomposition:
- Shared package/include (alongside the ALU control definitions):
  - state encodings IDLE=2'd0, REQ=2'd1, RESP=2'd2.
  - Funct3 size constants LS_B, LS_H, LS_W, LS_BU, LS_HU.
- Sub-module load_extend (combinational): inputs word, addr[1:0], Funct3; output extended data. It is reused by the writeback stage.

Test Plan:
- LW addr=0x100, memory ready after 2 cycles with 0xDEADBEEF -> mem_be=1111, mem_addr=0x100, stall high 4 cycles, rdata=0xDEADBEEF with rdata_vld for 1 cycle.
- LB addr=0x103, word 0x80FF_0000 -> mem_be=1000, rdata=0xFFFFFF80. LBU same stimulus -> rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200, no rdata_vld.
- LW addr=0x101 -> access_err pulse, mem_req never asserted, stall=0. Funct3=011 -> same result.
- rst_n low for 1 cycle while in REQ -> mem_req and stall drop immediately, FSM in IDLE. Next request proceeds normally.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=16, mem_ready held low -> mem_req drops after 16 REQ cycles, access_err pulse, rdata=0.
